seq_bin_div: RTL

Sequential restoring unsigned divider: 12-bit dividend ÷ 6-bit divisor, producing a 12-bit quotient and a 6-bit remainder. It is the inverse-direction companion to the team's 6×6 combinational array multiplier, so that `quotient * divisor + remainder == dividend` holds for every product the multiplier emits. It resolves one quotient bit per clock behind a start/busy/done handshake and sits beside the multiplier in the datapath.

---
 rtl/div_pkg.sv | 14 +
 rtl/seq_bin_div_if.sv | 23 ++
 rtl/div_step.sv | 18 +
 rtl/seq_bin_div.sv | 107 ++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and width constants for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DVD_W = 12;
    localparam int unsigned DVR_W = 6;
    localparam int unsigned CNT_W = $clog2(DVD_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_bin_div_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_bin_div_if;
    import div_pkg::*;

    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVR_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVR_W-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring trial-subtract: keeps the difference when it does not borrow.
module div_step
    import div_pkg::*;
(
    input  logic [DVR_W:0]   e,
    input  logic [DVR_W-1:0] dvr,
    output logic [DVR_W-1:0] r_nxt_c,
    output logic             q_bit_c
);

    logic [DVR_W:0] dvr_ext_c;

    assign dvr_ext_c = {1'b0, dvr};
    assign q_bit_c   = (e >= dvr_ext_c);
    // Dropping the top bit is safe: a successful subtract of a non-zero divisor is below it.
    assign r_nxt_c   = q_bit_c ? DVR_W'(e - dvr_ext_c) : e[DVR_W-1:0];

endmodule

// File: rtl/seq_bin_div.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional `DIV_BZ_CHECK_EN: a zero divisor skips the iterations and flags div_zero.
module seq_bin_div
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    seq_bin_div_if.slave bus
);

    state_t           state;
    logic [DVD_W-1:0] q_reg;
    logic [DVR_W-1:0] r_reg;
    logic [DVR_W-1:0] dvr_reg;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             done_r;
    logic [DVD_W-1:0] quo_r;
    logic [DVR_W-1:0] rem_r;

    logic [DVR_W-1:0] r_step_c;
    logic             q_bit_c;
    logic [DVD_W-1:0] q_shift_c;

    div_step u_step (
        .e       ({r_reg, q_reg[DVD_W-1]}),
        .dvr     (dvr_reg),
        .r_nxt_c (r_step_c),
        .q_bit_c (q_bit_c)
    );

    assign q_shift_c = {q_reg[DVD_W-2:0], q_bit_c};

`ifdef DIV_BZ_CHECK_EN
    logic dz_r;
    assign bus.div_zero = dz_r;
`else
    assign bus.div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q_reg   <= '0;
            r_reg   <= '0;
            dvr_reg <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            quo_r   <= '0;
            rem_r   <= '0;
`ifdef DIV_BZ_CHECK_EN
            dz_r    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        q_reg   <= bus.dividend;
                        r_reg   <= '0;
                        dvr_reg <= bus.divisor;
                        cnt     <= '0;
`ifdef DIV_BZ_CHECK_EN
                        if (bus.divisor == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            quo_r  <= '1;
                            rem_r  <= '0;
                            dz_r   <= 1'b1;
                        end else
`endif
                        begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    q_reg <= q_shift_c;
                    r_reg <= r_step_c;
                    cnt   <= cnt + CNT_W'(1);
                    // Last iteration: publish the finished result only.
                    if (cnt == CNT_W'(DVD_W - 1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        quo_r  <= q_shift_c;
                        rem_r  <= r_step_c;
`ifdef DIV_BZ_CHECK_EN
                        dz_r   <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;

endmodule
